// File: rtl/igual_2b2b_gen.sv
// rtl/igual_2b2b_gen.sv - sweeps all 2-bit operand pairs into an equality comparator
// and scores its answers against the expected X==Y result.
module igual_2b2b_gen #(
   parameter int PASSES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       ready,
   input  logic       eq_in,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] match_cnt,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);

   state_t     state;
   logic [3:0] idx;
   logic [3:0] pass_cnt;
   logic [3:0] idx_nxt;
   logic       expected;
   logic       mismatch;
   logic       last_xfer;

   assign idx_nxt   = idx + 4'd1;
   assign expected  = (idx[3:2] == idx[1:0]);
   assign mismatch  = (eq_in != expected);
   assign last_xfer = (idx == 4'hF) && (pass_cnt == PASS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 4'd0;
         pass_cnt  <= 4'd0;
         {A, B, C, D} <= 4'd0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         match_cnt <= 8'd0;
         err_cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= DRIVE;
                  idx       <= 4'd0;
                  pass_cnt  <= 4'd0;
                  {A, B, C, D} <= 4'd0;
                  valid     <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  match_cnt <= 8'd0;
                  err_cnt   <= 8'd0;
               end
            end
            DRIVE: begin
               // Operands and valid only move on a transfer, so a stall holds them.
               if (ready) begin
                  if (eq_in && match_cnt != 8'hFF)
                     match_cnt <= match_cnt + 8'd1;
                  if (mismatch && err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
                  if (last_xfer) begin
                     state <= DONE;
                     idx   <= 4'd0;
                     {A, B, C, D} <= 4'd0;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx <= idx_nxt;
                     {A, B, C, D} <= idx_nxt;
                     if (idx == 4'hF)
                        pass_cnt <= pass_cnt + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_igual_2b2b_gen.sv
// tb/tb_igual_2b2b_gen.sv - self-checking bench for igual_2b2b_gen
module tb_igual_2b2b_gen;

   logic       clk = 1'b0;
   logic       rst_n, start, ready, eq_in;
   logic       A, B, C, D, valid, busy, done;
   logic [7:0] match_cnt, err_cnt;
   int         emode;
   bit         eq_rand;

   logic       start3, ready3, eq3;
   logic       A3, B3, C3, D3, valid3, busy3, done3;
   logic [7:0] match3, err3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   igual_2b2b_gen #(.PASSES(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .eq_in(eq_in),
      .A(A), .B(B), .C(C), .D(D), .valid(valid), .busy(busy), .done(done),
      .match_cnt(match_cnt), .err_cnt(err_cnt)
   );

   igual_2b2b_gen #(.PASSES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .ready(ready3), .eq_in(eq3),
      .A(A3), .B(B3), .C(C3), .D(D3), .valid(valid3), .busy(busy3), .done(done3),
      .match_cnt(match3), .err_cnt(err3)
   );

   // Comparator stand-in: ideal, stuck-at-1, stuck-at-0 or random.
   always_comb begin
      eq_in = 1'b0;
      case (emode)
         0:       eq_in = ({A, B} == {C, D});
         1:       eq_in = 1'b1;
         2:       eq_in = 1'b0;
         default: eq_in = eq_rand;
      endcase
   end

   assign eq3 = ({A3, B3} == {C3, D3});

   typedef struct {
      int rmode;
      int emode;
      int exp_match;
      int exp_err;
      int exp_cycles;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_idle_done(input string tag);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_abcd"}, int'({A, B, C, D}), 0);
   endtask

   // Drives one run on dut; the model tracks which pair should be showing
   // (transfer number mod 16) and the scores a correct scorer would give.
   task automatic do_run(input int rmode, input int em,
                         output int mm, output int me, output int xf,
                         output int cyc, output int bad);
      logic [3:0] p;
      bit         e, x;
      mm = 0; me = 0; xf = 0; cyc = 0; bad = 0;
      emode = em;
      @(negedge clk);
      start = 1'b1;
      ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!done && cyc < 300) begin
         p = 4'(xf % 16);
         if (!(valid && busy && {A, B, C, D} == p)) bad++;
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = ((cyc % 2) == 1);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         eq_rand = 1'($urandom_range(0, 1));
         x = (p[3:2] == p[1:0]);
         case (em)
            0:       e = x;
            1:       e = 1'b1;
            2:       e = 1'b0;
            default: e = eq_rand;
         endcase
         if (ready) begin
            mm += int'(e);
            me += int'(e != x);
            xf++;
         end
         @(negedge clk);
         cyc++;
      end
      ready = 1'b0;
   endtask

   initial begin
      int mm, me, xf, cyc, bad;
      logic [3:0] p;

      vecs[0] = '{0, 0, 4, 0, 16};
      vecs[1] = '{1, 0, 4, 0, 32};
      vecs[2] = '{0, 1, 16, 12, 16};
      vecs[3] = '{0, 2, 0, 4, 16};
      vecs[4] = '{1, 1, 16, 12, 32};

      rst_n = 1'b0; start = 1'b0; ready = 1'b0; emode = 0; eq_rand = 1'b0;
      start3 = 1'b0; ready3 = 1'b0;

      @(negedge clk);
      check("rst_abcd", int'({A, B, C, D}), 0);
      check("rst_flags", int'({valid, busy, done}), 0);
      check("rst_cnts", int'({match_cnt, err_cnt}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_hold", int'({valid, busy, done}), 0);

      foreach (vecs[i]) begin
         do_run(vecs[i].rmode, vecs[i].emode, mm, me, xf, cyc, bad);
         check($sformatf("vec%0d_match", i), int'(match_cnt), vecs[i].exp_match);
         check($sformatf("vec%0d_err", i), int'(err_cnt), vecs[i].exp_err);
         check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
         check($sformatf("vec%0d_pairs", i), bad, 0);
         check_idle_done($sformatf("vec%0d", i));
      end
      repeat (3) @(negedge clk);
      check("done_held", int'({done, match_cnt}), int'({1'b1, 8'd16}));

      for (int r = 0; r < 4; r++) begin
         do_run(2, (r % 2 == 0) ? 3 : 0, mm, me, xf, cyc, bad);
         check($sformatf("rnd%0d_match", r), int'(match_cnt), mm);
         check($sformatf("rnd%0d_err", r), int'(err_cnt), me);
         check($sformatf("rnd%0d_xfers", r), xf, 16);
         check($sformatf("rnd%0d_pairs", r), bad, 0);
         check_idle_done($sformatf("rnd%0d", r));
      end

      // Reset mid-run at pair 7.
      emode = 0;
      @(negedge clk);
      start = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while ({A, B, C, D} != 4'd7 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("rst7_reached", int'({A, B, C, D}), 7);
      #2 rst_n = 1'b0;
      #1;
      check("rst7_async_abcd", int'({A, B, C, D}), 0);
      check("rst7_async_flags", int'({valid, busy, done}), 0);
      check("rst7_async_cnts", int'({match_cnt, err_cnt}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst7_idle", int'({valid, busy, done}), 0);
      do_run(0, 0, mm, me, xf, cyc, bad);
      check("rst7_rerun_match", int'(match_cnt), 4);
      check("rst7_rerun_err", int'(err_cnt), 0);
      check("rst7_rerun_pairs", bad, 0);

      // start held high through DRIVE and DONE.
      emode = 0;
      @(negedge clk);
      start = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      cyc = 0; bad = 0;
      while (!done && cyc < 100) begin
         p = 4'(cyc % 16);
         if (!(valid && {A, B, C, D} == p)) bad++;
         @(negedge clk);
         cyc++;
      end
      check("hold_cycles", cyc, 16);
      check("hold_pairs", bad, 0);
      check("hold_done_cnts", int'({match_cnt, err_cnt}), int'({8'd4, 8'd0}));
      @(negedge clk);
      start = 1'b0;
      check("hold_restart_flags", int'({valid, busy, done}), int'(3'b110));
      check("hold_restart_abcd", int'({A, B, C, D}), 0);
      check("hold_restart_cnts", int'({match_cnt, err_cnt}), 0);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("hold_second_cycles", cyc, 16);
      check("hold_second_match", int'(match_cnt), 4);
      ready = 1'b0;

      // PASSES=3 instance with random back-pressure.
      @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      xf = 0; cyc = 0; bad = 0; mm = 0;
      while (!done3 && cyc < 600) begin
         p = 4'(xf % 16);
         if (!(valid3 && busy3 && {A3, B3, C3, D3} == p)) bad++;
         ready3 = 1'($urandom_range(0, 1));
         if (ready3) begin
            mm += int'(p[3:2] == p[1:0]);
            xf++;
         end
         @(negedge clk);
         cyc++;
      end
      ready3 = 1'b0;
      check("p3_xfers", xf, 48);
      check("p3_pairs", bad, 0);
      check("p3_match_model", int'(match3), mm);
      check("p3_match", int'(match3), 12);
      check("p3_err", int'(err3), 0);
      repeat (5) @(negedge clk);
      check("p3_done_once", int'({done3, busy3, valid3, match3}), int'({3'b100, 8'd12}));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
